rggen_external_bridge: RTL and testbench
========================================

RGGEN_EXTERNAL_BRIDGE -- requirements
Module: rggen_external_bridge

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, local register-bus address width.
REQ-002 SHALL have parameter START_ADDRESS, default 0, first byte address of the external window.
REQ-003 SHALL have parameter END_ADDRESS, default 'hFF, last byte address of the external window.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, data width; strobe width is DATA_WIDTH/8.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 0, bus-request cycles before forced error; 0 disables timeout.
REQ-006 SHALL have parameter ERROR_ON_TIMEOUT, default 1; 1 returns RGGEN_SLAVE_ERROR on timeout, 0 returns RGGEN_OKAY with zero data.
REQ-007 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port register_control_if  rggen_register_if.control  --  local request, address, direction, done, status.
REQ-010 SHALL have port register_data_if  rggen_register_if.data  --  write data/strobe in; read data/value out.
REQ-011 SHALL have port bus_if  rggen_bus_if.master  --  external request, address, direction, write data/strobe; done, status, read data in.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse when a timeout terminates an access.

Function
REQ-013 SHALL decode a hit when control request is high and START_ADDRESS <= address <= END_ADDRESS; no hit, no action.
REQ-014 SHALL use external address width EXT_AW = max(1, $clog2(END_ADDRESS-START_ADDRESS+1)); bus address = (address - START_ADDRESS) truncated to EXT_AW bits.
REQ-015 SHALL implement FSM IDLE, REQUEST, RESPONSE; IDLE->REQUEST on hit; REQUEST->RESPONSE on bus done or timeout; RESPONSE->IDLE unconditionally after one cycle.
REQ-016 SHALL latch address offset, direction, write data and strobe on IDLE->REQUEST and hold them constant through REQUEST.
REQ-017 SHALL drive bus request high exactly while in REQUEST; bus fields zero/RGGEN_READ otherwise.
REQ-018 SHALL capture bus read data and status on the REQUEST cycle in which bus done is high.
REQ-019 SHALL assert control done exactly one cycle, in RESPONSE, with captured status; read data and value equal captured data, zero outside RESPONSE.
REQ-020 SHALL produce latency: hit sampled cycle N -> bus request from N+1; bus done cycle M -> control done cycle M+1.
REQ-021 SHALL, with TIMEOUT_CYCLES>0, count REQUEST cycles from 0 (cleared on entry) and terminate when count reaches TIMEOUT_CYCLES-1 without done.
REQ-022 SHALL on timeout capture data 0 and status per ERROR_ON_TIMEOUT, pulse timeout, and drop bus request next cycle.
REQ-023 SHALL give bus done priority over timeout when both occur in the same cycle; timeout then does not pulse.
REQ-024 SHALL ignore bus done/status/read data outside REQUEST (late responses after timeout are discarded).
REQ-025 SHALL accept a new hit in the IDLE cycle directly following RESPONSE (back-to-back).
REQ-026 SHALL size the timeout counter at $clog2(TIMEOUT_CYCLES+1) bits, minimum 1; no wrap-around is reachable.

Reset
REQ-027 SHALL on rst high immediately force IDLE: bus request 0, address 0, direction RGGEN_READ, write data/strobe 0, control done 0, status RGGEN_OKAY, read data 0, timeout 0, counter 0.
REQ-028 SHALL abort any access in flight on reset mid-operation, with no done generated afterwards for it.

Structure
REQ-029 SHALL take rggen_direction and rggen_status from rggen_rtl_pkg; FSM state enum stays local to the module.
REQ-030 SHALL isolate the timeout counter in sub-module rggen_timeout_counter (clear, enable, expire out), absent when TIMEOUT_CYCLES=0.

Verification
REQ-031 SHALL cover write hit: START='h100, END='h1FF, write 'h124 data 'hDEADBEEF strobe 'hF -> bus address 'h24 next cycle, bus done 3 cycles later -> control done 1 cycle after, status OKAY.
REQ-032 SHALL cover read: bus returns 'h12345678 with SLAVE_ERROR -> control read data 'h12345678, status SLAVE_ERROR, done for exactly 1 cycle.
REQ-033 SHALL cover timeout: TIMEOUT_CYCLES=8, bus never done -> bus request high 8 cycles, timeout pulse, done with SLAVE_ERROR and data 0; late bus done ignored.
REQ-034 SHALL cover done and timeout coincident on cycle 8 -> bus status/data returned, no timeout pulse.
REQ-035 SHALL cover miss 'h200 and back-to-back hits -> no bus request on miss; second hit's bus request starts the cycle after IDLE re-entry.
REQ-036 SHALL cover rst asserted mid-REQUEST -> bus request low asynchronously, no control done generated for the aborted access.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types: transfer direction, response status and a
// width helper used to size the external address bus.
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    // Bits needed to index 'value' distinct locations, never less than one.
    function automatic int rggen_clog2_min1(input longint value);
        int width;
        width = 0;
        while ((longint'(1) << width) < value) begin
            width++;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/rggen_external_bridge_if.sv
// Local register-bus and external-bus interfaces used by the bridge.
interface rggen_register_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    import rggen_rtl_pkg::*;

    logic                      request;
    logic [ADDRESS_WIDTH-1:0]  address;
    rggen_direction            direction;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   strobe;
    logic                      done;
    rggen_status               status;
    logic [DATA_WIDTH-1:0]     read_data;
    logic [DATA_WIDTH-1:0]     value;

    modport host (
        output request, address, direction, write_data, strobe,
        input  done, status, read_data, value
    );
    modport control (
        input  request, address, direction,
        output done, status
    );
    modport data (
        input  write_data, strobe,
        output read_data, value
    );
endinterface

interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
);
    import rggen_rtl_pkg::*;

    logic                      request;
    logic [ADDRESS_WIDTH-1:0]  address;
    rggen_direction            direction;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   strobe;
    logic                      done;
    rggen_status               status;
    logic [DATA_WIDTH-1:0]     read_data;

    modport master (
        output request, address, direction, write_data, strobe,
        input  done, status, read_data
    );
    modport slave (
        input  request, address, direction, write_data, strobe,
        output done, status, read_data
    );
endinterface

// File: rtl/rggen_timeout_counter.sv
// Counts cycles of an outstanding external request and flags the last
// permitted cycle so the bridge can terminate the access.
module rggen_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1
)(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Cycle counter: zeroed while idle, advances once per request cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);
endmodule

// File: rtl/rggen_external_bridge.sv
// Forwards register accesses that fall inside an address window to an
// external bus, returning its response (or a timeout response) one cycle
// after the external side completes.
module rggen_external_bridge #(
    parameter int                     ADDRESS_WIDTH    = 16,
    parameter bit [ADDRESS_WIDTH-1:0] START_ADDRESS    = '0,
    parameter bit [ADDRESS_WIDTH-1:0] END_ADDRESS      = ADDRESS_WIDTH'('hFF),
    parameter int                     DATA_WIDTH       = 32,
    parameter int unsigned            TIMEOUT_CYCLES   = 0,
    parameter bit                     ERROR_ON_TIMEOUT = 1'b1
)(
    input  logic              clk,
    input  logic              rst,
    rggen_register_if.control register_control_if,
    rggen_register_if.data    register_data_if,
    rggen_bus_if.master       bus_if,
    output logic              timeout
);
    import rggen_rtl_pkg::*;

    localparam int EXT_AW =
        rggen_clog2_min1(longint'(END_ADDRESS) - longint'(START_ADDRESS) + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RESPONSE
    } state_e;

    state_e                  state;
    logic                    above_start;
    logic                    below_end;
    logic                    hit;
    logic                    expire;
    logic                    bus_request;
    logic [EXT_AW-1:0]       bus_address;
    rggen_direction          bus_direction;
    logic [DATA_WIDTH-1:0]   bus_write_data;
    logic [DATA_WIDTH/8-1:0] bus_strobe;
    logic                    done;
    rggen_status             status;
    logic [DATA_WIDTH-1:0]   read_data;

    // Window bounds at the edges of the address space are constant-true.
    if (START_ADDRESS == '0) begin : g_no_lower
        assign above_start = 1'b1;
    end else begin : g_lower
        assign above_start = register_control_if.address >= START_ADDRESS;
    end

    if (END_ADDRESS == '1) begin : g_no_upper
        assign below_end = 1'b1;
    end else begin : g_upper
        assign below_end = register_control_if.address <= END_ADDRESS;
    end

    assign hit = register_control_if.request && above_start && below_end;

    if (TIMEOUT_CYCLES > 0) begin : g_timeout
        rggen_timeout_counter #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_timeout_counter (
            .clk    (clk),
            .rst    (rst),
            .clear  (state == IDLE),
            .enable (state == REQUEST),
            .expire (expire)
        );
    end else begin : g_no_timeout
        assign expire = 1'b0;
    end

    // Access sequencer; every bus and response output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus_request    <= 1'b0;
            bus_address    <= '0;
            bus_direction  <= RGGEN_READ;
            bus_write_data <= '0;
            bus_strobe     <= '0;
            done           <= 1'b0;
            status         <= RGGEN_OKAY;
            read_data      <= '0;
            timeout        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    status    <= RGGEN_OKAY;
                    read_data <= '0;
                    timeout   <= 1'b0;
                    if (hit) begin
                        state          <= REQUEST;
                        bus_request    <= 1'b1;
                        bus_address    <= EXT_AW'(register_control_if.address - START_ADDRESS);
                        bus_direction  <= register_control_if.direction;
                        bus_write_data <= register_data_if.write_data;
                        bus_strobe     <= register_data_if.strobe;
                    end
                end
                REQUEST: begin
                    // A real response wins over a timeout landing on the same cycle.
                    if (bus_if.done || expire) begin
                        state          <= RESPONSE;
                        bus_request    <= 1'b0;
                        bus_address    <= '0;
                        bus_direction  <= RGGEN_READ;
                        bus_write_data <= '0;
                        bus_strobe     <= '0;
                        done           <= 1'b1;
                        if (bus_if.done) begin
                            status    <= bus_if.status;
                            read_data <= bus_if.read_data;
                        end else begin
                            if (ERROR_ON_TIMEOUT) begin
                                status <= RGGEN_SLAVE_ERROR;
                            end else begin
                                status <= RGGEN_OKAY;
                            end
                            read_data <= '0;
                            timeout   <= 1'b1;
                        end
                    end
                end
                RESPONSE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    status    <= RGGEN_OKAY;
                    read_data <= '0;
                    timeout   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus_if.request             = bus_request;
    assign bus_if.address             = bus_address;
    assign bus_if.direction           = bus_direction;
    assign bus_if.write_data          = bus_write_data;
    assign bus_if.strobe              = bus_strobe;
    assign register_control_if.done   = done;
    assign register_control_if.status = status;
    assign register_data_if.read_data = read_data;
    assign register_data_if.value     = read_data;
endmodule

// File: tb/tb_rggen_external_bridge.sv
// Directed bench for the external bridge: one instance without timeout and
// one with an 8-cycle timeout, both decoding the window 'h100..'h1FF.
module tb_rggen_external_bridge;
    import rggen_rtl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic timeout0;
    logic timeout1;
    int   n_checks = 0;
    int   n_fails  = 0;

    rggen_register_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) reg0 (), reg1 ();
    rggen_bus_if      #(.ADDRESS_WIDTH(8),  .DATA_WIDTH(32)) bus0 (), bus1 ();

    always #5 clk = ~clk;

    rggen_external_bridge #(
        .ADDRESS_WIDTH    (16),
        .START_ADDRESS    (16'h0100),
        .END_ADDRESS      (16'h01FF),
        .DATA_WIDTH       (32),
        .TIMEOUT_CYCLES   (0),
        .ERROR_ON_TIMEOUT (1'b1)
    ) dut0 (
        .clk                 (clk),
        .rst                 (rst),
        .register_control_if (reg0),
        .register_data_if    (reg0),
        .bus_if              (bus0),
        .timeout             (timeout0)
    );

    rggen_external_bridge #(
        .ADDRESS_WIDTH    (16),
        .START_ADDRESS    (16'h0100),
        .END_ADDRESS      (16'h01FF),
        .DATA_WIDTH       (32),
        .TIMEOUT_CYCLES   (8),
        .ERROR_ON_TIMEOUT (1'b1)
    ) dut1 (
        .clk                 (clk),
        .rst                 (rst),
        .register_control_if (reg1),
        .register_data_if    (reg1),
        .bus_if              (bus1),
        .timeout             (timeout1)
    );

    task automatic check_value(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: actual 'h%0h required 'h%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reg0.request = 1'b0; reg0.address = '0; reg0.direction = RGGEN_READ;
        reg0.write_data = '0; reg0.strobe = '0;
        reg1.request = 1'b0; reg1.address = '0; reg1.direction = RGGEN_READ;
        reg1.write_data = '0; reg1.strobe = '0;
        bus0.done = 1'b0; bus0.status = RGGEN_OKAY; bus0.read_data = '0;
        bus1.done = 1'b0; bus1.status = RGGEN_OKAY; bus1.read_data = '0;
        rst = 1'b1;

        // Reset state
        tick();
        check_value("rst_bus_req",   bus0.request,    1'b0);
        check_value("rst_bus_addr",  bus0.address,    8'h00);
        check_value("rst_bus_dir",   bus0.direction,  RGGEN_READ);
        check_value("rst_bus_wdata", bus0.write_data, 32'h0);
        check_value("rst_bus_strb",  bus0.strobe,     4'h0);
        check_value("rst_done",      reg0.done,       1'b0);
        check_value("rst_status",    reg0.status,     RGGEN_OKAY);
        check_value("rst_rdata",     reg0.read_data,  32'h0);
        check_value("rst_timeout0",  timeout0,        1'b0);
        check_value("rst_bus1_req",  bus1.request,    1'b0);
        check_value("rst_timeout1",  timeout1,        1'b0);
        rst = 1'b0;
        tick();

        // Write hit at 'h124, external done on the fourth request cycle
        reg0.request = 1'b1; reg0.address = 16'h0124; reg0.direction = RGGEN_WRITE;
        reg0.write_data = 32'hDEADBEEF; reg0.strobe = 4'hF;
        tick();
        check_value("wr_bus_req",   bus0.request,    1'b1);
        check_value("wr_bus_addr",  bus0.address,    8'h24);
        check_value("wr_bus_dir",   bus0.direction,  RGGEN_WRITE);
        check_value("wr_bus_wdata", bus0.write_data, 32'hDEADBEEF);
        check_value("wr_bus_strb",  bus0.strobe,     4'hF);
        reg0.write_data = 32'h0; reg0.address = 16'h0130; reg0.strobe = 4'h1;
        tick();
        check_value("wr_hold_wdata", bus0.write_data, 32'hDEADBEEF);
        check_value("wr_hold_addr",  bus0.address,    8'h24);
        check_value("wr_hold_strb",  bus0.strobe,     4'hF);
        tick();
        check_value("wr_wait_done", reg0.done, 1'b0);
        tick();
        check_value("wr_req_before_done", bus0.request, 1'b1);
        bus0.done = 1'b1; bus0.status = RGGEN_OKAY;
        tick();
        check_value("wr_done",       reg0.done,       1'b1);
        check_value("wr_status",     reg0.status,     RGGEN_OKAY);
        check_value("wr_bus_req_lo", bus0.request,    1'b0);
        check_value("wr_bus_addr_0", bus0.address,    8'h00);
        check_value("wr_bus_dir_rd", bus0.direction,  RGGEN_READ);
        check_value("wr_bus_wd_0",   bus0.write_data, 32'h0);
        bus0.done = 1'b0; reg0.request = 1'b0;
        tick();
        check_value("wr_done_clear", reg0.done, 1'b0);

        // Read returning data with a slave error
        reg0.request = 1'b1; reg0.address = 16'h0130; reg0.direction = RGGEN_READ;
        tick();
        check_value("rd_bus_req",  bus0.request,   1'b1);
        check_value("rd_bus_addr", bus0.address,   8'h30);
        check_value("rd_bus_dir",  bus0.direction, RGGEN_READ);
        check_value("rd_rdata_pre", reg0.read_data, 32'h0);
        bus0.done = 1'b1; bus0.read_data = 32'h12345678; bus0.status = RGGEN_SLAVE_ERROR;
        tick();
        check_value("rd_done",   reg0.done,      1'b1);
        check_value("rd_rdata",  reg0.read_data, 32'h12345678);
        check_value("rd_value",  reg0.value,     32'h12345678);
        check_value("rd_status", reg0.status,    RGGEN_SLAVE_ERROR);
        bus0.done = 1'b0; reg0.request = 1'b0;
        tick();
        check_value("rd_done_1cyc", reg0.done,      1'b0);
        check_value("rd_rdata_0",   reg0.read_data, 32'h0);
        check_value("rd_status_ok", reg0.status,    RGGEN_OKAY);
        bus0.read_data = 32'h0; bus0.status = RGGEN_OKAY;

        // Misses above and below the window
        reg0.request = 1'b1; reg0.address = 16'h0200;
        tick();
        check_value("miss_hi_req", bus0.request, 1'b0);
        reg0.address = 16'h00FF;
        tick();
        check_value("miss_lo_req", bus0.request, 1'b0);
        tick();
        check_value("miss_done", reg0.done, 1'b0);

        // Back-to-back hits
        reg0.address = 16'h0104;
        tick();
        check_value("b2b1_req",  bus0.request, 1'b1);
        check_value("b2b1_addr", bus0.address, 8'h04);
        bus0.done = 1'b1; bus0.read_data = 32'hA5A5A5A5;
        tick();
        check_value("b2b1_done",  reg0.done,      1'b1);
        check_value("b2b1_rdata", reg0.read_data, 32'hA5A5A5A5);
        bus0.done = 1'b0; bus0.read_data = 32'h0; reg0.address = 16'h01F0;
        tick();
        check_value("b2b_idle_req",  bus0.request, 1'b0);
        check_value("b2b_idle_done", reg0.done,    1'b0);
        tick();
        check_value("b2b2_req",  bus0.request, 1'b1);
        check_value("b2b2_addr", bus0.address, 8'hF0);
        bus0.done = 1'b1;
        tick();
        check_value("b2b2_done", reg0.done, 1'b1);
        bus0.done = 1'b0; reg0.request = 1'b0;
        tick();

        // Timeout with the external side never responding
        reg1.request = 1'b1; reg1.address = 16'h01FC; reg1.direction = RGGEN_WRITE;
        reg1.write_data = 32'h1; reg1.strobe = 4'h3;
        bus1.read_data = 32'hBAD0BAD0; bus1.status = RGGEN_OKAY;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_value($sformatf("to_req_%0d", i),  bus1.request, 1'b1);
            check_value($sformatf("to_pulse_%0d", i), timeout1,    1'b0);
            check_value($sformatf("to_done_%0d", i),  reg1.done,   1'b0);
            if (i == 0) check_value("to_addr", bus1.address, 8'hFC);
        end
        tick();
        check_value("to_req_lo", bus1.request,   1'b0);
        check_value("to_pulse",  timeout1,       1'b1);
        check_value("to_done",   reg1.done,      1'b1);
        check_value("to_status", reg1.status,    RGGEN_SLAVE_ERROR);
        check_value("to_rdata",  reg1.read_data, 32'h0);
        bus1.done = 1'b1; bus1.read_data = 32'h0000CAFE; reg1.request = 1'b0;
        tick();
        check_value("late_done",  reg1.done,      1'b0);
        check_value("late_pulse", timeout1,       1'b0);
        check_value("late_rdata", reg1.read_data, 32'h0);
        check_value("late_req",   bus1.request,   1'b0);
        tick();
        check_value("late_done2", reg1.done, 1'b0);
        bus1.done = 1'b0; bus1.read_data = 32'h0;

        // External done on the same cycle the timeout would fire
        reg1.request = 1'b1; reg1.address = 16'h0100; reg1.direction = RGGEN_READ;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_value($sformatf("co_req_%0d", i), bus1.request, 1'b1);
            if (i == 7) begin
                bus1.done = 1'b1; bus1.read_data = 32'h87654321; bus1.status = RGGEN_OKAY;
            end
        end
        tick();
        check_value("co_done",   reg1.done,      1'b1);
        check_value("co_status", reg1.status,    RGGEN_OKAY);
        check_value("co_rdata",  reg1.read_data, 32'h87654321);
        check_value("co_pulse",  timeout1,       1'b0);
        check_value("co_req_lo", bus1.request,   1'b0);
        bus1.done = 1'b0; reg1.request = 1'b0;
        tick();
        check_value("co_done_clear", reg1.done, 1'b0);

        // Reset during an outstanding request
        reg0.request = 1'b1; reg0.address = 16'h0110; reg0.direction = RGGEN_WRITE;
        reg0.write_data = 32'h55; reg0.strobe = 4'h1;
        tick();
        check_value("ra_req", bus0.request, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_value("ra_req_async",  bus0.request, 1'b0);
        check_value("ra_addr_async", bus0.address, 8'h00);
        reg0.request = 1'b0;
        bus0.done = 1'b1; bus0.status = RGGEN_SLAVE_ERROR;
        tick();
        rst = 1'b0;
        tick();
        check_value("ra_no_done", reg0.done,    1'b0);
        check_value("ra_req_lo",  bus0.request, 1'b0);
        tick();
        check_value("ra_no_done2", reg0.done, 1'b0);
        bus0.done = 1'b0; bus0.status = RGGEN_OKAY;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
